jtag_scan_sequencer: RTL

JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

---
 rtl/jtag_scan_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: turns TLR / IR-scan / DR-scan / idle-cycle commands
// into a registered TMS/TDI stream and returns the captured TDO bits.
module jtag_scan_sequencer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk_tck,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              tdo,
  output logic              tms,
  output logic              tdi,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data
);

  // Each state names the TAP state the target occupies during that cycle.
  localparam logic [3:0] INIT_TLR = 4'd0;
  localparam logic [3:0] IDLE     = 4'd1;
  localparam logic [3:0] SEL_DR   = 4'd2;
  localparam logic [3:0] SEL_IR   = 4'd3;
  localparam logic [3:0] CAPTURE  = 4'd4;
  localparam logic [3:0] SHIFT    = 4'd5;
  localparam logic [3:0] EXIT1    = 4'd6;
  localparam logic [3:0] UPDATE   = 4'd7;
  localparam logic [3:0] RUN_IDLE = 4'd8;
  localparam logic [3:0] IDLE_CYC = 4'd9;
  localparam logic [3:0] RESP     = 4'd10;

  localparam logic [1:0] OP_TLR  = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_DR   = 2'd2;
  localparam logic [1:0] OP_IDLE = 2'd3;

  // The counter must also reach 6 for the TLR sequence.
  localparam int CNT_W = (LEN_W < 3) ? 3 : LEN_W;

  logic [3:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              act, act_nx;
  logic [1:0]        op_r, op_nx;
  logic [LEN_W-1:0]  len_r, len_nx;
  logic [DATA_W-1:0] data_r, data_nx;
  logic [DATA_W-1:0] cap, cap_nx;
  logic [DATA_W-1:0] sh;
  logic              rsp_nx, err_nx, tdi_nx, hs, len_bad;

  // TMS value driven while the target sits in state st.
  function automatic logic tms_of(input logic [3:0] st, input logic [CNT_W-1:0] c,
                                  input logic [1:0] op, input logic [LEN_W-1:0] len);
    case (st)
      INIT_TLR:        tms_of = (c != CNT_W'(6));
      RUN_IDLE, EXIT1: tms_of = 1'b1;
      SEL_DR:          tms_of = (op == OP_IR);
      SHIFT:           tms_of = (c == CNT_W'(len) - CNT_W'(1));
      default:         tms_of = 1'b0;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign hs        = cmd_valid && cmd_ready;
  assign len_bad   = (cmd_len == '0) || (int'(cmd_len) > DATA_W);

  // Next-state, command latch and TDO capture logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    act_nx   = act;
    op_nx    = op_r;
    len_nx   = len_r;
    data_nx  = data_r;
    cap_nx   = cap;
    rsp_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      INIT_TLR: begin
        if (cnt == CNT_W'(6)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          rsp_nx   = act;
          act_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        if (hs) begin
          op_nx   = cmd_op;
          len_nx  = cmd_len;
          data_nx = cmd_data;
          cap_nx  = '0;
          cnt_nx  = '0;
          case (cmd_op)
            OP_TLR: begin
              state_nx = INIT_TLR;
              cnt_nx   = CNT_W'(1);
              act_nx   = 1'b1;
            end
            OP_IDLE: begin
              if (cmd_len == '0) rsp_nx = 1'b1;
              else               state_nx = IDLE_CYC;
            end
            default: begin
              if (len_bad) begin
                state_nx = RESP;
                rsp_nx   = 1'b1;
                err_nx   = 1'b1;
              end else begin
                state_nx = RUN_IDLE;
              end
            end
          endcase
        end
      end
      RUN_IDLE: state_nx = SEL_DR;
      SEL_DR:   state_nx = (op_r == OP_DR) ? CAPTURE : SEL_IR;
      SEL_IR:   state_nx = CAPTURE;
      CAPTURE:  state_nx = SHIFT;
      SHIFT: begin
        cap_nx = cap | (DATA_W'(tdo) << cnt);
        if (cnt == CNT_W'(len_r) - CNT_W'(1)) begin
          state_nx = EXIT1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      EXIT1:  state_nx = UPDATE;
      UPDATE: begin
        state_nx = IDLE;
        rsp_nx   = 1'b1;
      end
      IDLE_CYC: begin
        if (cnt == CNT_W'(len_r) - CNT_W'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          rsp_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = INIT_TLR;
    endcase
    sh     = data_nx >> cnt_nx;
    tdi_nx = (state_nx == SHIFT) && sh[0];
  end

  // Control state and registered TAP/response outputs.
  always_ff @(posedge clk_tck) begin
    if (reset) begin
      state     <= INIT_TLR;
      cnt       <= '0;
      act       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      act       <= act_nx;
      tms       <= tms_of(state_nx, cnt_nx, op_nx, len_nx);
      tdi       <= tdi_nx;
      rsp_valid <= rsp_nx;
      rsp_err   <= err_nx;
      if (rsp_nx) rsp_data <= cap_nx;
    end
  end

  // Command operands and capture shift register; cleared on acceptance.
  always_ff @(posedge clk_tck) begin
    op_r   <= op_nx;
    len_r  <= len_nx;
    data_r <= data_nx;
    cap    <= cap_nx;
  end

endmodule
